// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control/datapath signal bundle for the multicycle sequencer
//
// Groups every signal that passes between mc_ctrl and the MIPS datapath.
//   master : sequencer side. It receives OP, Zero and mem_ready, and drives the
//            mux selects, write enables, status and debug outputs.
//   slave  : datapath side, with the directions reversed.
// CNT_W sets the width of retired_cnt and must match the mc_ctrl instance.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       OP;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             pc_en;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             RegDst;
    logic             Mem2Reg;
    logic             RegWrite;
    logic             JalSel;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic [3:0]       state;

    modport master (
        input  OP, Zero, mem_ready,
        output PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, Mem2Reg, RegWrite,
               JalSel, illegal, retire, retired_cnt, state
    );

    modport slave (
        output OP, Zero, mem_ready,
        input  PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, Mem2Reg, RegWrite,
               JalSel, illegal, retire, retired_cnt, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control sequencer (Moore FSM + retire counter)
//
// This is a Moore FSM. It steps the shared datapath through fetch, decode,
// execute, memory and write-back for each instruction, and counts the
// instructions that retire.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mc_ctrl_if.master: carries the OP/Zero/mem_ready inputs, the
//          datapath controls, illegal, retire, retired_cnt and state (debug)
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite;
    logic       w_irwrite, w_alusrca, w_regdst, w_mem2reg, w_regwrite;
    logic       w_jalsel, w_illegal, w_retire;
    logic [1:0] w_alusrcb, w_aluop, w_pcsource;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_aluop       = 2'b00;
        w_pcsource    = 2'b00;
        w_regdst      = 1'b0;
        w_mem2reg     = 1'b0;
        w_regwrite    = 1'b0;
        w_jalsel      = 1'b0;
        w_illegal     = 1'b0;
        w_retire      = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 goes straight to the PC through the ALU. IR and PC
                // only load on the cycle the memory read completes.
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
                w_next    = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Compute the branch target into ALUOut now. BRANCH then
                // needs only one extra cycle.
                w_alusrcb = 2'b11;
                case (bus.OP)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J, OP_JAL: w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (bus.OP == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord    = 1'b1;
                w_memread = 1'b1;
                w_next    = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_mem2reg  = 1'b1;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = bus.mem_ready;
                w_next     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca     = 1'b1;
                w_aluop       = 2'b01;
                w_pcsource    = 2'b01;
                w_pcwritecond = 1'b1;
                w_retire      = 1'b1;
            end
            S_JUMP: begin
                // For jal, the RF writes the current PC (already PC+4) to $31
                // on the same edge that the PC takes the jump target.
                w_pcsource = 2'b10;
                w_pcwrite  = 1'b1;
                w_retire   = 1'b1;
                w_regwrite = (bus.OP == OP_JAL);
                w_jalsel   = (bus.OP == OP_JAL);
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset blocks every write and strobe, so an abandoned instruction
        // leaves no side effects.
        if (reset) begin
            w_pcwrite     = 1'b0;
            w_pcwritecond = 1'b0;
            w_irwrite     = 1'b0;
            w_memread     = 1'b0;
            w_memwrite    = 1'b0;
            w_regwrite    = 1'b0;
            w_retire      = 1'b0;
            w_illegal     = 1'b0;
        end
    end

    assign bus.PCWrite     = w_pcwrite;
    assign bus.PCWriteCond = w_pcwritecond;
    assign bus.pc_en       = w_pcwrite | (w_pcwritecond & bus.Zero);
    assign bus.IorD        = w_iord;
    assign bus.MemRead     = w_memread;
    assign bus.MemWrite    = w_memwrite;
    assign bus.IRWrite     = w_irwrite;
    assign bus.ALUSrcA     = w_alusrca;
    assign bus.ALUSrcB     = w_alusrcb;
    assign bus.ALUOp       = w_aluop;
    assign bus.PCSource    = w_pcsource;
    assign bus.RegDst      = w_regdst;
    assign bus.Mem2Reg     = w_mem2reg;
    assign bus.RegWrite    = w_regwrite;
    assign bus.JalSel      = w_jalsel;
    assign bus.illegal     = w_illegal;
    assign bus.retire      = w_retire;
    assign bus.retired_cnt = r_cnt;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a path-queue model
module tb_mc_ctrl;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mr;

    mc_ctrl_if #(.CNT_W(32)) bus ();
    mc_ctrl_if #(.CNT_W(4))  bus4 ();

    mc_ctrl #(.CNT_W(32)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    mc_ctrl #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

    assign bus.OP         = op;
    assign bus.Zero       = zero;
    assign bus.mem_ready  = mr;
    assign bus4.OP        = op;
    assign bus4.Zero      = zero;
    assign bus4.mem_ready = mr;

    always #5 clk = ~clk;

    // Observed control vector. Bit order matches exp_vec below.
    wire logic [19:0] w_obs = {bus.PCWrite, bus.PCWriteCond, bus.pc_en, bus.IorD,
                               bus.MemRead, bus.MemWrite, bus.IRWrite, bus.ALUSrcA,
                               bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.RegDst,
                               bus.Mem2Reg, bus.RegWrite, bus.JalSel, bus.illegal,
                               bus.retire};
    // Strobes that must be zero while reset is high.
    wire logic [8:0] w_strobes = {bus.PCWrite, bus.PCWriteCond, bus.pc_en, bus.IRWrite,
                                  bus.MemRead, bus.MemWrite, bus.RegWrite, bus.retire,
                                  bus.illegal};

    typedef struct {
        int st;
        bit mr;
    } step_t;

    step_t       q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_cnt = '0;
    int          zero_mode = -1;   // -1 random, else forced value

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) ||
               (o == OP_J) || (o == OP_JAL) || (o == OP_ADDI);
    endfunction

    // Expected controls for one step, taken from the per-step output table.
    function automatic logic [19:0] exp_vec(input int st, input logic [5:0] o,
                                            input bit m, input bit z);
        logic pcw = 0, pcwc = 0, pce = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, asa = 0;
        logic [1:0] asb = 0, aop = 0, pcs = 0;
        logic rdst = 0, m2r = 0, rw = 0, jal = 0, ill = 0, ret = 0;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = m; pcw = m; pce = m; end
            1:  begin asb = 2'b11; ill = !is_legal(o); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; ret = 1; end
            5:  begin iord = 1; mwr = 1; ret = m; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; ret = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcwc = 1; ret = 1; pce = z; end
            9:  begin pcs = 2'b10; pcw = 1; pce = 1; ret = 1;
                      rw = (o == OP_JAL); jal = (o == OP_JAL); end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; ret = 1; end
            default: ;
        endcase
        return {pcw, pcwc, pce, iord, mrd, mwr, irw, asa, asb, aop, pcs,
                rdst, m2r, rw, jal, ill, ret};
    endfunction

    task automatic push(input int st, input bit m);
        step_t s;
        s.st = st;
        s.mr = m;
        q.push_back(s);
    endtask

    task automatic push_wait(input int st, input int w);
        for (int i = 0; i < w; i++) push(st, 1'b0);
        push(st, 1'b1);
    endtask

    // Expected state path of one instruction, with wf fetch and wm memory stalls.
    task automatic build(input logic [5:0] o, input int wf, input int wm);
        push_wait(0, wf);
        push(1, 1'($urandom));
        case (o)
            OP_R:         begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
            OP_LW:        begin push(2, 1'($urandom)); push_wait(3, wm); push(4, 1'($urandom)); end
            OP_SW:        begin push(2, 1'($urandom)); push_wait(5, wm); end
            OP_BEQ:       push(8, 1'($urandom));
            OP_J, OP_JAL: push(9, 1'($urandom));
            OP_ADDI:      begin push(10, 1'($urandom)); push(11, 1'($urandom)); end
            default: ;
        endcase
    endtask

    task automatic run_queue(input logic [5:0] o);
        step_t s;
        logic [19:0] e;
        while (q.size() > 0) begin
            s    = q.pop_front();
            op   = o;
            mr   = s.mr;
            zero = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
            #1;
            e = exp_vec(s.st, o, s.mr, zero);
            chk("state", 32'(bus.state), 32'(s.st));
            chk("ctrl", 32'(w_obs), 32'(e));
            if (e[0]) m_cnt = m_cnt + 1;
            @(posedge clk);
            #1;
        end
        chk("retired_cnt", bus.retired_cnt, m_cnt);
        chk("retired_cnt4", 32'(bus4.retired_cnt), 32'(m_cnt[3:0]));
    endtask

    task automatic instr(input logic [5:0] o, input int wf, input int wm);
        build(o, wf, wm);
        run_queue(o);
    endtask

    logic [5:0] ops[8];
    logic [5:0] ro;

    initial begin
        ops[0] = OP_R;   ops[1] = OP_LW; ops[2] = OP_SW;  ops[3] = OP_BEQ;
        ops[4] = OP_J;   ops[5] = OP_JAL; ops[6] = OP_ADDI; ops[7] = 6'b111111;

        // Reset
        reset = 1'b1; op = '0; zero = 1'b0; mr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_cnt", bus.retired_cnt, 32'd0);
        chk("rst_strobes", 32'(w_strobes), 32'd0);
        reset = 1'b0;

        // add/lw/sw/beq/jal with no stalls; beq taken
        zero_mode = 1;
        instr(OP_R, 0, 0);
        instr(OP_LW, 0, 0);
        instr(OP_SW, 0, 0);
        instr(OP_BEQ, 0, 0);
        instr(OP_JAL, 0, 0);
        zero_mode = -1;
        chk("prog_cnt", bus.retired_cnt, 32'd5);

        // beq not taken
        zero_mode = 0;
        instr(OP_BEQ, 0, 0);
        zero_mode = -1;

        // Illegal opcode: no retire, back to FETCH
        instr(6'b111111, 0, 0);
        chk("illegal_cnt", bus.retired_cnt, 32'd6);

        // lw with three MEMRD stalls
        instr(OP_LW, 0, 3);

        // Ten more legal instructions bring the total to 17, so the 4-bit counter shows 1
        for (int i = 0; i < 10; i++) begin
            instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2));
        end
        chk("cnt4_wrap", 32'(bus4.retired_cnt), 32'd1);
        chk("cnt_17", bus.retired_cnt, 32'd17);

        // Random mix including random (possibly illegal) opcodes
        for (int i = 0; i < 60; i++) begin
            ro = ops[$urandom_range(0, 7)];
            if (ro == 6'b111111) ro = 6'($urandom);
            instr(ro, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while stalled in MEMWR
        build(OP_SW, 0, 0);
        void'(q.pop_back());           // stop before MEMWR
        run_queue(OP_SW);
        mr = 1'b0;
        #1;
        chk("memwr_state", 32'(bus.state), 32'd5);
        chk("memwr_ctrl", 32'(w_obs), 32'(exp_vec(5, OP_SW, 1'b0, zero)));
        reset = 1'b1;
        #1;
        chk("memwr_rst_strobes", 32'(w_strobes), 32'd0);
        @(posedge clk);
        #1;
        chk("memwr_rst_state", 32'(bus.state), 32'd0);
        chk("memwr_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        chk("memwr_rst_cnt", bus.retired_cnt, 32'd0);
        chk("memwr_rst_cnt4", 32'(bus4.retired_cnt), 32'd0);
        reset = 1'b0;
        m_cnt = '0;
        instr(OP_ADDI, 1, 0);
        chk("post_rst_cnt", bus.retired_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control sequencer for the MIPS core. Moore FSM that drives the shared datapath (single memory port, one ALU reused for PC+4, branch target and execute) through fetch, decode, execute, memory and write-back steps. Waits on a memory-ready handshake and counts retired instructions. Sits between the instruction register (opcode/funct source) and every datapath mux and write enable.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- OP  in  6  instr[31:26] from instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite / PCWriteCond  out  1  unconditional / branch-qualified PC update
- pc_en  out  1  PCWrite | (PCWriteCond & Zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead / MemWrite  out  1  memory strobes
- IRWrite  out  1  load instruction register
- ALUSrcA  out  1  0 = PC, 1 = rs data
- ALUSrcB  out  2  00 rt data, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
- ALUOp  out  2  00 add, 01 sub, 10 decode from funct
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], instr[25:0], 00}
- RegDst / Mem2Reg / RegWrite  out  1  write address select (1 = rd), write-data select (1 = memory), RF write enable
- JalSel  out  1  force write address 31, write data = PC
- illegal  out  1  unrecognised opcode in DECODE
- retire  out  1  one-cycle pulse on instruction completion
- retired_cnt  out  CNT_W  retired-instruction count
- state  out  4  current state (debug)

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011, addi 001000. All else illegal.
- Outputs are a function of state only (Moore), except that FETCH IRWrite/PCWrite and MEMWR retire are qualified by mem_ready. Unlisted outputs are 0.
- FETCH(0): IorD=0, MemRead, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready. Hold until mem_ready, then DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j/jal→JUMP, addi→ADDIEX, illegal→FETCH with illegal=1.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw→MEMRD, sw→MEMWR.
- MEMRD(3): IorD=1, MemRead. Hold until mem_ready, then MEMWB.
- MEMWB(4): RegDst=0, Mem2Reg=1, RegWrite, retire. →FETCH.
- MEMWR(5): IorD=1, MemWrite held every cycle until mem_ready; retire=mem_ready. →FETCH on mem_ready.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. →ALUWB(7): RegDst=1, Mem2Reg=0, RegWrite, retire. →FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond, retire. →FETCH.
- JUMP(9): PCSource=10, PCWrite, retire; for jal also RegWrite, JalSel (RF captures pre-update PC = PC+4 on the same edge). →FETCH.
- ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. →ADDIWB(11): RegDst=0, Mem2Reg=0, RegWrite, retire. →FETCH.
- OP is sampled only after IR load; IRWrite is asserted only in FETCH, so OP is stable from DECODE to completion.
- retired_cnt increments by 1 on every retire cycle and wraps from 2^CNT_W−1 to 0.
- Illegal opcode is not counted as retired.

## Timing
- Reset: next edge gives state=FETCH and retired_cnt=0. While reset is high, PCWrite, PCWriteCond, pc_en, IRWrite, MemRead, MemWrite, RegWrite, retire and illegal are forced 0 regardless of state. Reset mid-instruction abandons it with no write.
- Latency with mem_ready always 1: lw 5, sw 4, R 4, addi 4, beq 3, j/jal 3 cycles.
- Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle; strobes and address select stay constant while waiting.
- mem_ready outside those states is ignored.
- Unused state encodings 12–15 go to FETCH next cycle with no strobes.

## Test plan
- Reset asserted in MEMWR with mem_ready=0 → next cycle state=0, MemWrite=0, retired_cnt=0; after release, FETCH begins.
- mem_ready=1, program add/lw/sw/beq(taken)/jal → state sequence 0,1,6,7 | 0,1,2,3,4 | 0,1,2,5 | 0,1,8 | 0,1,9; retired_cnt=5 after 19 cycles.
- beq with Zero=0 → pc_en=0 in BRANCH; with Zero=1 → pc_en=1, PCSource=01.
- lw with mem_ready low 3 cycles in MEMRD → MemRead/IorD=1 held 4 cycles, RegWrite only in MEMWB, total 8 cycles.
- OP=111111 → illegal=1 in DECODE, no RegWrite/MemWrite, next state FETCH, retired_cnt unchanged.
- CNT_W=4, retire 17 instructions → retired_cnt=1.
